// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search cluster.
// Provides the dispatcher state enum and the default key width/type.
package rc4_pkg;

  localparam int DEF_KEY_WIDTH = 24;

  typedef logic [DEF_KEY_WIDTH-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } dispatch_state_t;

endpackage

// File: rtl/key_dispatcher_if.sv
// Core <-> dispatcher bundle: requests, done/hit reports, block grants.
// master: dispatcher side (drives grants); slave: core side.
interface key_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_WIDTH = 24
);

  logic [NUM_CORES-1:0]           core_req;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_hit;
  logic [NUM_CORES*KEY_WIDTH-1:0] hit_key;
  logic [NUM_CORES-1:0]           core_gnt;
  logic [KEY_WIDTH-1:0]           gnt_base;
  logic [KEY_WIDTH-1:0]           gnt_last;

  modport master (
    input  core_req,
    input  core_done,
    input  core_hit,
    input  hit_key,
    output core_gnt,
    output gnt_base,
    output gnt_last
  );

  modport slave (
    output core_req,
    output core_done,
    output core_hit,
    output hit_key,
    input  core_gnt,
    input  gnt_base,
    input  gnt_last
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible bit at or after ptr.
// Ports: elig/ptr in; one-hot gnt, encoded idx, any out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!any && elig[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/key_dispatcher.sv
// Dynamic key-block scheduler for parallel RC4 search cores.
// Ports: clk, reset (async low), start/abort pulses, cores bundle,
// status stop/busy/done/found and latched found_key/found_core.
module key_dispatcher
  import rc4_pkg::*;
#(
  parameter int                   NUM_CORES     = 2,
  parameter int                   LOG_NUM_CORES = 1,
  parameter int                   KEY_WIDTH     = DEF_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = 24'h3FFFFF,
  parameter int                   BLOCK_LOG     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  key_dispatcher_if.master         cores,
  output logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [KEY_WIDTH-1:0]     found_key,
  output logic [LOG_NUM_CORES-1:0] found_core
);

  localparam logic [KEY_WIDTH:0] BLK =
    {{KEY_WIDTH{1'b0}}, 1'b1} << BLOCK_LOG;
  localparam logic [KEY_WIDTH:0] BLK_M1 = BLK - 1'b1;
  localparam logic [KEY_WIDTH:0] KMAX_X = {1'b0, KEY_MAX};

  dispatch_state_t state, state_nx;

  logic [NUM_CORES-1:0]     outst;
  logic [NUM_CORES-1:0]     elig;
  logic [NUM_CORES-1:0]     hit_q;
  logic [NUM_CORES-1:0]     arb_gnt;
  logic [NUM_CORES-1:0]     gnt_q;
  logic [LOG_NUM_CORES-1:0] rr_ptr;
  logic [LOG_NUM_CORES-1:0] arb_idx;
  logic [LOG_NUM_CORES-1:0] win_idx;
  logic [KEY_WIDTH-1:0]     win_key;
  logic [KEY_WIDTH-1:0]     base_q;
  logic [KEY_WIDTH-1:0]     last_q;
  // One extra bit so the counter can step past KEY_MAX without wrapping.
  logic [KEY_WIDTH:0]       next_base;
  logic [KEY_WIDTH:0]       blk_end;
  logic                     arb_any;
  logic                     any_hit;
  logic                     exhausted;
  logic                     searching;
  logic                     grant_en;
  logic                     start_ok;
  logic                     hit_take;
  logic                     aborted_q;
  logic                     found_q;

  assign elig      = cores.core_req & ~outst;
  // Reports from cores without a block in flight are ignored.
  assign hit_q     = cores.core_hit & outst;
  assign any_hit   = |hit_q;
  assign exhausted = next_base > KMAX_X;
  assign blk_end   = next_base + BLK_M1;
  assign searching = (state == DISPATCH) || (state == DRAIN);
  assign start_ok  = start && !abort && !searching;
  assign hit_take  = any_hit && !abort && searching;
  // A hit blocks any grant so no new block escapes after the win.
  assign grant_en  = (state == DISPATCH) && arb_any &&
                     !exhausted && !any_hit && !abort;

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (LOG_NUM_CORES)
  ) u_arb (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Lowest-index hitting core wins.
  always_comb begin
    win_idx = '0;
    win_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_idx = LOG_NUM_CORES'(i);
        win_key = cores.hit_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_nx = DISPATCH;
        DISPATCH: begin
          if (any_hit)        state_nx = FOUND;
          else if (exhausted) state_nx = DRAIN;
        end
        DRAIN: begin
          if (any_hit)         state_nx = FOUND;
          else if (outst == 0) state_nx = EXHAUSTED;
        end
        FOUND:     if (start) state_nx = DISPATCH;
        EXHAUSTED: if (start) state_nx = DISPATCH;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    stop = aborted_q;
    unique case (state)
      DISPATCH, DRAIN: busy = 1'b1;
      FOUND, EXHAUSTED: begin
        done = 1'b1;
        stop = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aborted_q  <= 1'b0;
      gnt_q      <= '0;
      base_q     <= '0;
      last_q     <= '0;
      next_base  <= '0;
      rr_ptr     <= '0;
      outst      <= '0;
      found_q    <= 1'b0;
      found_key  <= '0;
      found_core <= '0;
    end else begin
      aborted_q <= abort;
      gnt_q     <= grant_en ? arb_gnt : '0;
      if (abort || start_ok) begin
        outst <= '0;
      end else begin
        outst <= (outst & ~(cores.core_done | cores.core_hit)) |
                 (grant_en ? arb_gnt : '0);
      end
      if (start_ok) begin
        next_base  <= '0;
        found_q    <= 1'b0;
        found_key  <= '0;
        found_core <= '0;
      end else if (grant_en) begin
        base_q    <= next_base[KEY_WIDTH-1:0];
        last_q    <= (blk_end > KMAX_X) ? KEY_MAX
                                        : blk_end[KEY_WIDTH-1:0];
        next_base <= next_base + BLK;
        rr_ptr    <= (arb_idx == LOG_NUM_CORES'(NUM_CORES - 1))
                     ? '0 : arb_idx + 1'b1;
      end else if (hit_take) begin
        found_q    <= 1'b1;
        found_key  <= win_key;
        found_core <= win_idx;
      end
    end
  end

  assign found          = found_q;
  assign cores.core_gnt = gnt_q;
  assign cores.gnt_base = base_q;
  assign cores.gnt_last = last_q;

endmodule

// File: tb/tb_key_dispatcher.sv
// Scoreboard bench for key_dispatcher: two instances, KEY_MAX 0xFFF
// and 0xA00, directed stimulus with hand-computed grant ranges.
module tb_key_dispatcher;

  typedef struct {
    logic [1:0]  gnt;
    logic [23:0] base;
    logic [23:0] last;
  } gnt_t;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b, abort;
  logic stop_a, busy_a, done_a, found_a;
  logic stop_b, busy_b, done_b, found_b;
  logic [23:0] fkey_a, fkey_b;
  logic [0:0]  fcore_a, fcore_b;

  int   checks = 0;
  int   errors = 0;
  gnt_t exp_a[$];
  gnt_t exp_b[$];
  gnt_t ea, eb;
  bit   auto_a, auto_b;
  int   cnt_a[2];
  int   cnt_b[2];
  logic [1:0] dn_a, dn_b;

  key_dispatcher_if #(.NUM_CORES(2), .KEY_WIDTH(24)) bus_a ();
  key_dispatcher_if #(.NUM_CORES(2), .KEY_WIDTH(24)) bus_b ();

  key_dispatcher #(
    .NUM_CORES(2), .LOG_NUM_CORES(1), .KEY_WIDTH(24),
    .KEY_MAX(24'h000FFF), .BLOCK_LOG(10)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort),
    .cores(bus_a), .stop(stop_a), .busy(busy_a), .done(done_a),
    .found(found_a), .found_key(fkey_a), .found_core(fcore_a)
  );

  key_dispatcher #(
    .NUM_CORES(2), .LOG_NUM_CORES(1), .KEY_WIDTH(24),
    .KEY_MAX(24'h000A00), .BLOCK_LOG(10)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort),
    .cores(bus_b), .stop(stop_b), .busy(busy_b), .done(done_b),
    .found(found_b), .found_key(fkey_b), .found_core(fcore_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && bus_a.core_gnt != 2'b00) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL gnt_a: got gnt=%b base=%h last=%h, no grant expected",
                 bus_a.core_gnt, bus_a.gnt_base, bus_a.gnt_last);
      end else begin
        ea = exp_a.pop_front();
        if (bus_a.core_gnt !== ea.gnt || bus_a.gnt_base !== ea.base ||
            bus_a.gnt_last !== ea.last) begin
          errors++;
          $display("FAIL gnt_a: got %b %h-%h expected %b %h-%h",
                   bus_a.core_gnt, bus_a.gnt_base, bus_a.gnt_last,
                   ea.gnt, ea.base, ea.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && bus_b.core_gnt != 2'b00) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL gnt_b: got gnt=%b base=%h last=%h, no grant expected",
                 bus_b.core_gnt, bus_b.gnt_base, bus_b.gnt_last);
      end else begin
        eb = exp_b.pop_front();
        if (bus_b.core_gnt !== eb.gnt || bus_b.gnt_base !== eb.base ||
            bus_b.gnt_last !== eb.last) begin
          errors++;
          $display("FAIL gnt_b: got %b %h-%h expected %b %h-%h",
                   bus_b.core_gnt, bus_b.gnt_base, bus_b.gnt_last,
                   eb.gnt, eb.base, eb.last);
        end
      end
    end
  end

  task automatic push(input bit b, input logic [1:0] g,
                      input logic [23:0] base, input logic [23:0] last);
    gnt_t e;
    e.gnt  = g;
    e.base = base;
    e.last = last;
    if (b) exp_b.push_back(e);
    else   exp_a.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: clear pulses, then model cores that report done 5
  // cycles after each grant when auto mode is on.
  task automatic tick();
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
    bus_a.core_hit = 2'b00;
    bus_b.core_hit = 2'b00;
    for (int i = 0; i < 2; i++) begin
      dn_a[i] = 1'b0;
      dn_b[i] = 1'b0;
      if (cnt_a[i] > 0) begin
        cnt_a[i]--;
        dn_a[i] = (cnt_a[i] == 0);
      end
      if (cnt_b[i] > 0) begin
        cnt_b[i]--;
        dn_b[i] = (cnt_b[i] == 0);
      end
      if (auto_a && bus_a.core_gnt[i]) cnt_a[i] = 5;
      if (auto_b && bus_b.core_gnt[i]) cnt_b[i] = 5;
    end
    bus_a.core_done = dn_a;
    bus_b.core_done = dn_b;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return bus_a.core_gnt[1];
      1: return done_a;
      2: return done_b;
      3: return bus_b.core_gnt[0] && (bus_b.gnt_last == 24'h000A00);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = cond(sel);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: event not seen, got timeout expected event", name);
    end
  endtask

  task automatic reset_dut();
    auto_a = 1'b0;
    auto_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
    auto_a  = 1'b0;
    auto_b  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    bus_a.core_req  = 2'b11;
    bus_b.core_req  = 2'b11;
    bus_a.core_done = 2'b00;
    bus_b.core_done = 2'b00;
    bus_a.core_hit  = 2'b00;
    bus_b.core_hit  = 2'b00;
    bus_a.hit_key   = '0;
    bus_b.hit_key   = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_gnt",   {30'd0, bus_a.core_gnt}, 32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_done",  {31'd0, done_a}, 32'd0);
    check("rst_stop",  {31'd0, stop_a}, 32'd0);
    check("rst_found", {31'd0, found_a}, 32'd0);
    check("rst_fkey",  {8'd0, fkey_a}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Exhaustion over 0x000-0xFFF.
    auto_a = 1'b1;
    push(0, 2'b01, 24'h000000, 24'h0003FF);
    push(0, 2'b10, 24'h000400, 24'h0007FF);
    push(0, 2'b01, 24'h000800, 24'h000BFF);
    push(0, 2'b10, 24'h000C00, 24'h000FFF);
    start_a = 1'b1;
    wait_for(1, "exh_wait");
    check("exh_done",  {31'd0, done_a}, 32'd1);
    check("exh_found", {31'd0, found_a}, 32'd0);
    check("exh_stop",  {31'd0, stop_a}, 32'd1);
    check("exh_busy",  {31'd0, busy_a}, 32'd0);
    check("exh_left",  exp_a.size(), 32'd0);

    // Mid-simulation asynchronous reset.
    #2 reset = 1'b0;
    #1;
    check("mrst_done", {31'd0, done_a}, 32'd0);
    check("mrst_stop", {31'd0, stop_a}, 32'd0);
    check("mrst_gnt",  {30'd0, bus_a.core_gnt}, 32'd0);
    tick();
    reset = 1'b1;
    auto_a = 1'b0;
    repeat (5) tick();
    check("mrst_idle", {31'd0, busy_a}, 32'd0);
    check("mrst_nogn", {30'd0, bus_a.core_gnt}, 32'd0);

    // Single hit from core1 during its first block.
    reset_dut();
    auto_a = 1'b1;
    push(0, 2'b01, 24'h000000, 24'h0003FF);
    push(0, 2'b10, 24'h000400, 24'h0007FF);
    start_a = 1'b1;
    wait_for(0, "hit_g1");
    bus_a.core_hit = 2'b10;
    bus_a.hit_key  = {24'h0005A3, 24'h000000};
    tick();
    check("hit_found", {31'd0, found_a}, 32'd1);
    check("hit_key",   {8'd0, fkey_a}, 32'h000005A3);
    check("hit_core",  {31'd0, fcore_a}, 32'd1);
    check("hit_stop",  {31'd0, stop_a}, 32'd1);
    check("hit_done",  {31'd0, done_a}, 32'd1);
    repeat (10) tick();
    check("hit_left",  exp_a.size(), 32'd0);

    // Simultaneous hits, then abort from FOUND keeps the result.
    reset_dut();
    push(0, 2'b01, 24'h000000, 24'h0003FF);
    push(0, 2'b10, 24'h000400, 24'h0007FF);
    start_a = 1'b1;
    wait_for(0, "sim_g1");
    bus_a.core_hit = 2'b11;
    bus_a.hit_key  = {24'h000456, 24'h000123};
    tick();
    check("sim_core",  {31'd0, fcore_a}, 32'd0);
    check("sim_key",   {8'd0, fkey_a}, 32'h00000123);
    abort = 1'b1;
    tick();
    check("fab_stop",  {31'd0, stop_a}, 32'd1);
    check("fab_done",  {31'd0, done_a}, 32'd0);
    check("fab_found", {31'd0, found_a}, 32'd1);
    check("fab_key",   {8'd0, fkey_a}, 32'h00000123);
    tick();
    check("fab_stop2", {31'd0, stop_a}, 32'd0);

    // Abort after two grants, restart, ignored start, abort+start.
    reset_dut();
    push(0, 2'b01, 24'h000000, 24'h0003FF);
    push(0, 2'b10, 24'h000400, 24'h0007FF);
    start_a = 1'b1;
    wait_for(0, "ab_g1");
    abort = 1'b1;
    tick();
    check("ab_stop",   {31'd0, stop_a}, 32'd1);
    check("ab_busy",   {31'd0, busy_a}, 32'd0);
    tick();
    check("ab_stop2",  {31'd0, stop_a}, 32'd0);
    push(0, 2'b01, 24'h000000, 24'h0003FF);
    push(0, 2'b10, 24'h000400, 24'h0007FF);
    start_a = 1'b1;
    wait_for(0, "ab_g2");
    start_a = 1'b1;
    repeat (4) tick();
    check("busy_start", {31'd0, busy_a}, 32'd1);
    check("ab_left",   exp_a.size(), 32'd0);
    abort   = 1'b1;
    start_a = 1'b1;
    tick();
    check("abst_busy", {31'd0, busy_a}, 32'd0);
    check("abst_stop", {31'd0, stop_a}, 32'd1);
    tick();
    check("abst_idle", {31'd0, busy_a}, 32'd0);

    // Clamped last block on the KEY_MAX=0xA00 instance.
    reset_dut();
    auto_b = 1'b1;
    push(1, 2'b01, 24'h000000, 24'h0003FF);
    push(1, 2'b10, 24'h000400, 24'h0007FF);
    push(1, 2'b01, 24'h000800, 24'h000A00);
    start_b = 1'b1;
    wait_for(3, "clamp_g3");
    tick();
    tick();
    check("drain_busy", {31'd0, busy_b}, 32'd1);
    check("drain_done", {31'd0, done_b}, 32'd0);
    wait_for(2, "clamp_exh");
    check("clamp_found", {31'd0, found_b}, 32'd0);
    check("clamp_stop",  {31'd0, stop_b}, 32'd1);
    check("clamp_left",  exp_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_dispatcher.md
Name: key_dispatcher

Overview:
Dynamic work scheduler for the parallel RC4 key-search cores. It replaces static per-core key partitioning: cores request fixed-size key blocks from a shared range [0, KEY_MAX], and the block grants them round-robin, one grant per cycle. It tracks outstanding blocks, latches the first successful key and its core index, and broadcasts a stop. It reports exhaustion when the range is consumed with no hit.

Parameters:
NUM_CORES, 2, number of requesting arcfour cores
LOG_NUM_CORES, 1, width of the core index
KEY_WIDTH, 24, key width in bits (KEY_LENGTH*RAM_WIDTH)
KEY_MAX, 24'h3FFFFF, last key in the search range (inclusive)
BLOCK_LOG, 10, log2 of keys per granted block

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a search from key 0
abort  in  1  single-cycle pulse; cancels the current search
core_req  in  NUM_CORES  level; core idle and wants a block
core_done  in  NUM_CORES  pulse; core finished its block with no hit
core_hit  in  NUM_CORES  pulse; core found a valid key
hit_key  in  NUM_CORES*KEY_WIDTH  per-core key, valid with core_hit
core_gnt  out  NUM_CORES  one-hot single-cycle grant pulse
gnt_base  out  KEY_WIDTH  first key of the granted block, valid with core_gnt
gnt_last  out  KEY_WIDTH  last key of the granted block (clamped to KEY_MAX), valid with core_gnt
stop  out  1  level; all cores must halt (FOUND, EXHAUSTED, and the abort cycle)
busy  out  1  state is DISPATCH or DRAIN
done  out  1  search ended (FOUND or EXHAUSTED)
found  out  1  search ended with a hit
found_key  out  KEY_WIDTH  latched winning key
found_core  out  LOG_NUM_CORES  latched winning core index

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0. rr_ptr=0, next_base=0, outstanding=0.
- next_base is a KEY_WIDTH+1 bit counter, so it cannot wrap. Range is exhausted when next_base > KEY_MAX.
- gnt_last = min(next_base + 2^BLOCK_LOG - 1, KEY_MAX).
- outstanding[i]: set on core_gnt[i]; cleared on core_done[i] or core_hit[i].
- Core i is eligible when core_req[i]=1 and outstanding[i]=0.
- core_done or core_hit from a core with outstanding[i]=0 is ignored.
- Arbitration is round-robin: search starts at rr_ptr and wraps. After a grant to core g, rr_ptr = (g+1) mod NUM_CORES.
- Grant latency: eligible request sampled in cycle N gives registered core_gnt, gnt_base and gnt_last in cycle N+1. next_base then advances by 2^BLOCK_LOG.
- Maximum one grant per cycle.
- States:
  - IDLE: start -> DISPATCH; clear next_base, outstanding, found, found_key, found_core.
  - DISPATCH: issue grants.
    - Any qualified hit -> FOUND.
    - Else, range exhausted -> DRAIN.
  - DRAIN: no grants.
    - Qualified hit -> FOUND.
    - Else, outstanding==0 -> EXHAUSTED.
  - FOUND: done=1, found=1, stop=1, no grants. start -> DISPATCH (fresh search).
  - EXHAUSTED: done=1, found=0, stop=1. start -> DISPATCH (fresh search).
- Simultaneous hits: the lowest-index core wins. found_key and found_core are latched in the cycle the hit is sampled.
- Hit in the same cycle as a request: the hit has priority and no grant is issued next cycle.
- Hit and done for the same core in the same cycle: treated as a hit.
- start while busy: ignored.
- abort in any state: -> IDLE and stop=1 for exactly one cycle. outstanding cleared; found registers hold their values.
- abort and start in the same cycle: abort wins.
- Range smaller than one block (KEY_MAX < 2^BLOCK_LOG): exactly one grant, with gnt_last=KEY_MAX.

Decomposition:
- Shared package rc4_pkg:
  - dispatch_state_t enum (IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED)
  - KEY_WIDTH default constant
  - key_t typedef
- Sub-module rr_arbiter (parameter N):
  - inputs: eligibility vector, rr_ptr
  - outputs: one-hot grant, encoded index, any_grant
  - combinational; the pointer register stays in key_dispatcher.

Test Plan:
Bench config: NUM_CORES=2, KEY_MAX=24'h000FFF, BLOCK_LOG=10 unless stated.
- Reset: hold reset=0 mid-simulation -> all outputs 0 immediately; after release, state IDLE and no grants despite core_req=2'b11.
- Exhaustion: start, core_req=2'b11 held, each core pulses core_done 5 cycles after its grant -> grants in order core0 0x000-0x3FF, core1 0x400-0x7FF, core0 0x800-0xBFF, core1 0xC00-0xFFF. Then after the last done: done=1, found=0, stop=1.
- Single hit: core1 pulses core_hit with hit_key 0x0005A3 during its first block -> found=1, found_key=0x0005A3, found_core=1, stop=1, no further core_gnt.
- Simultaneous hits: core0 key 0x000123 and core1 key 0x000456 in the same cycle -> found_core=0, found_key=0x000123.
- Clamping: KEY_MAX=24'h000A00 -> grant ranges 0x000-0x3FF, 0x400-0x7FF, 0x800-0xA00, then DRAIN.
- Abort: abort after 2 grants -> stop high for 1 cycle, IDLE, busy=0. A following start restarts with gnt_base=0x000.
